// File: rtl/sort_check_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sort_check_pkg
// Description : Shared state encoding and arithmetic helpers for the sort
//               result checker.
// Revision    : 1.0 - initial release
// ============================================================================
package sort_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int c_CALC_W = 64;

    // Saturating +1 for any counter up to 64 bits wide.
    function automatic logic [c_CALC_W-1:0] sat_inc(input logic [c_CALC_W-1:0] value,
                                                   input int unsigned width);
        logic [c_CALC_W-1:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= max_val) ? max_val : value + 64'd1;
    endfunction

    // Left-justifying both operands keeps the sign bit at bit 63, so one
    // 64-bit compare serves every data width.
    function automatic logic order_violation(input logic [c_CALC_W-1:0] cur,
                                             input logic [c_CALC_W-1:0] prev,
                                             input int unsigned width,
                                             input logic descending,
                                             input logic is_signed);
        logic [c_CALC_W-1:0] a;
        logic [c_CALC_W-1:0] b;
        logic gt;
        logic lt;
        a = cur << (64 - width);
        b = prev << (64 - width);
        if (is_signed) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return descending ? gt : lt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sort_result_checker_cycle_budget.sv
`default_nettype none
// ============================================================================
// Module      : cycle_budget_counter
// Description : Saturating cycle counter with freeze and sticky over-budget.
// Revision    : 1.0 - initial release
// ============================================================================
module cycle_budget_counter
    import sort_check_pkg::*;
#(
    parameter int          CYC_W      = 32,
    parameter int unsigned MAX_CYCLES = 25840
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_freeze,
    output logic [CYC_W-1:0] o_count,
    output logic             o_over_budget
);

    logic [CYC_W-1:0] r_count;
    logic             r_over;
    logic [CYC_W-1:0] w_count_next;

    always_comb begin
        w_count_next = r_count;
        if (!i_freeze) begin
            w_count_next = CYC_W'(sat_inc(64'(r_count), CYC_W));
        end
    end

    // Flag is evaluated on the next value so it rises with the count itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_over  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_over  <= r_over | (64'(w_count_next) > 64'(MAX_CYCLES));
        end
    end

    assign o_count       = r_count;
    assign o_over_budget = r_over;

endmodule
`default_nettype wire

// File: rtl/sort_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : sort_result_checker
// Description : Scans N dmem words after start, counting order violations and
//               expected-table mismatches, and times reset-to-start cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module sort_result_checker
    import sort_check_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          N          = 96,
    parameter int          BASE_WORD  = 32,
    parameter int          ADDR_W     = 10,
    parameter int          DESCENDING = 1,
    parameter int          SIGNED     = 0,
    parameter int          ERR_W      = 9,
    parameter int unsigned MAX_CYCLES = 25840,
    parameter int          CYC_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_rdata,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_unsorted,
    output logic [ERR_W-1:0]  err_exp,
    output logic              pass_sorted,
    output logic              pass_exp,
    output logic [CYC_W-1:0]  cycle_count,
    output logic              over_budget
);

    generate
        if (N < 2 || DATA_W > 64 || CYC_W > 64 || ERR_W > 64 ||
            (longint'(BASE_WORD) + longint'(N)) > (longint'(1) << ADDR_W)) begin : g_param_check
            $error("sort_result_checker: illegal parameter set (N/BASE_WORD/ADDR_W/widths)");
        end
    endgenerate

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_k;
    logic              r_tail;
    logic              r_cap_v;
    logic              r_cap_first;
    logic [DATA_W-1:0] r_cap_mem;
    logic [DATA_W-1:0] r_cap_exp;
    logic [DATA_W-1:0] r_prev;
    logic [ERR_W-1:0]  r_err_unsorted;
    logic [ERR_W-1:0]  r_err_exp;
    logic              w_start_scan;
    logic              w_last_k;

    assign w_start_scan = start && (r_state != SCAN);
    assign w_last_k     = (r_k == ADDR_W'(N - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = SCAN;
            SCAN:    if (r_tail) w_state_next = DONE;
            DONE:    if (start)  w_state_next = SCAN;
            default: w_state_next = IDLE;
        endcase
    end

    // Read words are captured one cycle, then scored the next; r_tail marks
    // the final scoring cycle, during which no further address is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_k            <= '0;
            r_tail         <= 1'b0;
            r_cap_v        <= 1'b0;
            r_cap_first    <= 1'b0;
            r_cap_mem      <= '0;
            r_cap_exp      <= '0;
            r_prev         <= '0;
            r_err_unsorted <= '0;
            r_err_exp      <= '0;
        end else if (w_start_scan) begin
            r_k            <= '0;
            r_tail         <= 1'b0;
            r_cap_v        <= 1'b0;
            r_err_unsorted <= '0;
            r_err_exp      <= '0;
        end else if (r_state == SCAN) begin
            r_cap_v <= !r_tail;
            if (!r_tail) begin
                r_cap_mem   <= mem_rdata;
                r_cap_exp   <= exp_rdata;
                r_cap_first <= (r_k == '0);
                if (w_last_k) begin
                    r_tail <= 1'b1;
                end else begin
                    r_k <= r_k + 1'b1;
                end
            end else begin
                r_k    <= '0;
                r_tail <= 1'b0;
            end
            if (r_cap_v) begin
                if (r_cap_mem != r_cap_exp) begin
                    r_err_exp <= ERR_W'(sat_inc(64'(r_err_exp), ERR_W));
                end
                if (!r_cap_first &&
                    order_violation(64'(r_cap_mem), 64'(r_prev), DATA_W,
                                    DESCENDING != 0, SIGNED != 0)) begin
                    r_err_unsorted <= ERR_W'(sat_inc(64'(r_err_unsorted), ERR_W));
                end
                r_prev <= r_cap_mem;
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            SCAN:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
        pass_sorted = done && (r_err_unsorted == '0);
        pass_exp    = done && (r_err_exp == '0);
    end

    assign mem_addr     = ADDR_W'(BASE_WORD) + r_k;
    assign exp_addr     = r_k;
    assign err_unsorted = r_err_unsorted;
    assign err_exp      = r_err_exp;

    cycle_budget_counter #(
        .CYC_W      (CYC_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_cycle_budget (
        .clk           (clk),
        .rst           (reset),
        .i_freeze      ((r_state != IDLE) || start),
        .o_count       (cycle_count),
        .o_over_budget (over_budget)
    );

endmodule
`default_nettype wire

// File: tb/tb_sort_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_sort_result_checker
// Description : Directed/random bench with array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sort_result_checker;

    localparam int c_N0    = 96;
    localparam int c_BASE0 = 32;
    localparam int c_N1    = 20;
    localparam int c_BASE1 = 200;
    localparam int c_MAXC  = 25840;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    logic [9:0]  ma0, ea0, ma1, ea1, ma2, ea2;
    logic [31:0] md0, ed0, md1, ed1, md2, ed2;
    logic        busy0, done0, ps0, pe0, ov0;
    logic        busy1, done1, ps1, pe1, ov1;
    logic        busy2, done2, ps2, pe2, ov2;
    logic [8:0]  eu0, ee0;
    logic [3:0]  eu1, ee1, eu2, ee2;
    logic [31:0] cc0, cc1, cc2;

    logic [31:0] dmem [0:1023];
    logic [31:0] exp0 [0:127];
    logic [31:0] exp1 [0:31];

    int checks = 0;
    int errors = 0;
    int max_addr0 = 0;
    int max_addr1 = 0;

    assign md0 = dmem[ma0];
    assign ed0 = exp0[ea0[6:0]];
    assign md1 = dmem[ma1];
    assign ed1 = exp1[ea1[4:0]];
    assign md2 = dmem[ma2];
    assign ed2 = exp1[ea2[4:0]];

    always #5 clk = ~clk;

    sort_result_checker #(
        .DATA_W(32), .N(c_N0), .BASE_WORD(c_BASE0), .ADDR_W(10), .DESCENDING(1),
        .SIGNED(0), .ERR_W(9), .MAX_CYCLES(c_MAXC), .CYC_W(32)
    ) dut0 (
        .clk(clk), .reset(reset), .start(start0), .mem_addr(ma0), .mem_rdata(md0),
        .exp_addr(ea0), .exp_rdata(ed0), .busy(busy0), .done(done0),
        .err_unsorted(eu0), .err_exp(ee0), .pass_sorted(ps0), .pass_exp(pe0),
        .cycle_count(cc0), .over_budget(ov0)
    );

    sort_result_checker #(
        .DATA_W(32), .N(c_N1), .BASE_WORD(c_BASE1), .ADDR_W(10), .DESCENDING(0),
        .SIGNED(1), .ERR_W(4), .MAX_CYCLES(c_MAXC), .CYC_W(32)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start1), .mem_addr(ma1), .mem_rdata(md1),
        .exp_addr(ea1), .exp_rdata(ed1), .busy(busy1), .done(done1),
        .err_unsorted(eu1), .err_exp(ee1), .pass_sorted(ps1), .pass_exp(pe1),
        .cycle_count(cc1), .over_budget(ov1)
    );

    sort_result_checker #(
        .DATA_W(32), .N(c_N1), .BASE_WORD(c_BASE1), .ADDR_W(10), .DESCENDING(0),
        .SIGNED(0), .ERR_W(4), .MAX_CYCLES(c_MAXC), .CYC_W(32)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start1), .mem_addr(ma2), .mem_rdata(md2),
        .exp_addr(ea2), .exp_rdata(ed2), .busy(busy2), .done(done2),
        .err_unsorted(eu2), .err_exp(ee2), .pass_sorted(ps2), .pass_exp(pe2),
        .cycle_count(cc2), .over_budget(ov2)
    );

    // Highest address presented while scanning, restarted by an accepted start.
    always @(posedge clk) begin
        if (start0 && !busy0) max_addr0 <= 0;
        else if (busy0 && int'(ma0) > max_addr0) max_addr0 <= int'(ma0);
        if (start1 && !busy1) max_addr1 <= 0;
        else if (busy1 && int'(ma1) > max_addr1) max_addr1 <= int'(ma1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: count rule breaks over the array, then clip at the counter ceiling.
    function automatic void model(input int base, input int n, input bit sgn, input bit desc,
                                  input int errw, input bit grp1, output int eu, output int ee);
        int ceiling;
        ceiling = (1 << errw) - 1;
        eu = 0;
        ee = 0;
        for (int i = 0; i < n; i++) begin
            logic [31:0] cur;
            logic [31:0] ex;
            cur = dmem[base + i];
            ex  = grp1 ? exp1[i] : exp0[i];
            if (cur != ex) ee++;
            if (i > 0) begin
                logic [31:0] prv;
                int sc, sp;
                longint uc, up;
                prv = dmem[base + i - 1];
                sc = cur;
                sp = prv;
                uc = longint'({32'd0, cur});
                up = longint'({32'd0, prv});
                if (sgn) begin
                    if (desc ? (sc > sp) : (sc < sp)) eu++;
                end else begin
                    if (desc ? (uc > up) : (uc < up)) eu++;
                end
            end
        end
        if (eu > ceiling) eu = ceiling;
        if (ee > ceiling) ee = ceiling;
    endfunction

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic scan0(input string tag, input int mid_start);
        int eu, ee;
        start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        for (int c = 1; c <= c_N0; c++) begin
            if (c == mid_start) start0 = 1'b1;
            @(posedge clk); #1 start0 = 1'b0;
        end
        check({tag, " busy at N"}, 64'(busy0), 64'(1));
        check({tag, " done at N"}, 64'(done0), 64'(0));
        @(posedge clk); #1;
        check({tag, " done at N+1"}, 64'(done0), 64'(1));
        check({tag, " busy at N+1"}, 64'(busy0), 64'(0));
        model(c_BASE0, c_N0, 1'b0, 1'b1, 9, 1'b0, eu, ee);
        check({tag, " err_unsorted"}, 64'(eu0), 64'(eu));
        check({tag, " err_exp"}, 64'(ee0), 64'(ee));
        check({tag, " pass_sorted"}, 64'(ps0), 64'(eu == 0));
        check({tag, " pass_exp"}, 64'(pe0), 64'(ee == 0));
        check({tag, " last addr"}, 64'(max_addr0), 64'(c_BASE0 + c_N0 - 1));
    endtask

    task automatic scan1(input string tag);
        int eu, ee;
        start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        repeat (c_N1) @(posedge clk);
        #1 check({tag, " done1 at N"}, 64'(done1), 64'(0));
        @(posedge clk); #1;
        check({tag, " done1 at N+1"}, 64'(done1), 64'(1));
        check({tag, " done2 at N+1"}, 64'(done2), 64'(1));
        model(c_BASE1, c_N1, 1'b1, 1'b0, 4, 1'b1, eu, ee);
        check({tag, " signed err_unsorted"}, 64'(eu1), 64'(eu));
        check({tag, " signed err_exp"}, 64'(ee1), 64'(ee));
        model(c_BASE1, c_N1, 1'b0, 1'b0, 4, 1'b1, eu, ee);
        check({tag, " unsigned err_unsorted"}, 64'(eu2), 64'(eu));
        check({tag, " unsigned err_exp"}, 64'(ee2), 64'(ee));
        check({tag, " last addr"}, 64'(max_addr1), 64'(c_BASE1 + c_N1 - 1));
    endtask

    task automatic fill_desc0();
        logic [31:0] v;
        v = 32'hE000_0000 + $urandom_range(0, 32'h00FF_FFFF);
        for (int i = 0; i < c_N0; i++) begin
            dmem[c_BASE0 + i] = v;
            exp0[i] = v;
            v = v - $urandom_range(1, 1000);
        end
    endtask

    task automatic fill_rand0(input int unsigned hi);
        for (int i = 0; i < c_N0; i++) begin
            dmem[c_BASE0 + i] = $urandom_range(0, hi);
            exp0[i] = ($urandom_range(0, 3) == 0) ? (dmem[c_BASE0 + i] ^ 32'd1) : dmem[c_BASE0 + i];
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] t;
        for (int i = 0; i < 1024; i++) dmem[i] = 32'd0;
        for (int i = 0; i < 128; i++) exp0[i] = 32'd0;
        for (int i = 0; i < 32; i++) exp1[i] = 32'd0;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset busy", 64'(busy0), 64'(0));
        check("reset done", 64'(done0), 64'(0));
        check("reset err_unsorted", 64'(eu0), 64'(0));
        check("reset err_exp", 64'(ee0), 64'(0));
        check("reset cycle_count", 64'(cc0), 64'(0));
        check("reset over_budget", 64'(ov0), 64'(0));
        check("reset mem_addr", 64'(ma0), 64'(c_BASE0));
        check("reset exp_addr", 64'(ea0), 64'(0));
        check("reset pass_sorted", 64'(ps0), 64'(0));

        fill_desc0();
        repeat (5) @(posedge clk);
        #1 scan0("sorted", 0);
        check("sorted cycle_count", 64'(cc0), 64'(5));
        check("sorted over_budget", 64'(ov0), 64'(0));

        t = dmem[40]; dmem[40] = dmem[41]; dmem[41] = t;
        repeat (4) @(posedge clk);
        #1 check("done holds", 64'(done0), 64'(1));
        check("count frozen in DONE", 64'(cc0), 64'(5));
        scan0("swap40_41", 0);
        check("rescan keeps count", 64'(cc0), 64'(5));

        fill_rand0(32'hFFFF_FFFF);
        scan0("random wide", 30);
        fill_rand0(7);
        scan0("random ties", 0);

        start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        repeat (50) @(posedge clk);
        #1 check("mid-scan busy", 64'(busy0), 64'(1));
        reset  = 1'b1;
        start0 = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        start0 = 1'b0;
        check("abort busy", 64'(busy0), 64'(0));
        check("abort done", 64'(done0), 64'(0));
        check("abort err_unsorted", 64'(eu0), 64'(0));
        check("abort err_exp", 64'(ee0), 64'(0));
        check("abort mem_addr", 64'(ma0), 64'(c_BASE0));
        check("abort cycle_count", 64'(cc0), 64'(0));
        scan0("after abort", 0);
        check("after abort cycle_count", 64'(cc0), 64'(0));

        pulse_reset();
        fill_desc0();
        repeat (c_MAXC) @(posedge clk);
        #1 check("budget edge count", 64'(cc0), 64'(c_MAXC));
        check("budget edge flag", 64'(ov0), 64'(0));
        @(posedge clk); #1;
        check("budget over count", 64'(cc0), 64'(c_MAXC + 1));
        check("budget over flag", 64'(ov0), 64'(1));
        scan0("over budget", 10);
        check("over budget frozen", 64'(cc0), 64'(c_MAXC + 1));
        check("over budget sticky", 64'(ov0), 64'(1));

        v = 32'h0000_203E;
        dmem[c_BASE1] = 32'hFFFF_8A4F;
        dmem[c_BASE1 + 1] = v;
        for (int i = 2; i < c_N1; i++) begin
            v = v + $urandom_range(1, 1000);
            dmem[c_BASE1 + i] = v;
        end
        for (int i = 0; i < c_N1; i++) exp1[i] = dmem[c_BASE1 + i];
        scan1("signed asc");
        for (int i = 0; i < c_N1; i++) exp1[i] = 32'd0;
        scan1("exp saturate");
        check("saturated err_exp", 64'(ee1), 64'(15));
        for (int i = 0; i < c_N1; i++) dmem[c_BASE1 + i] = $urandom();
        scan1("random small");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sort_result_checker.md
Name: sort_result_checker

Overview:
Synthesisable, parametrised result checker for sort workloads running on single_cycle_mips.
- After a start pulse (e.g. PC reaching the end PC), it scans N words of data memory through a read port, one word per cycle.
- It counts adjacent-order violations and mismatches against an expected-value memory, and measures cycles from reset release to start against a budget.
- It sits beside cpu.dmem, so pass/fail is observable in hardware rather than only in a bench.

Parameters:
DATA_W, 32, word width
N, 96, number of words checked (>=2)
BASE_WORD, 32, word index of first element in dmem
ADDR_W, 10, word-address width of both read ports
DESCENDING, 1, 1: require mem[i] >= mem[i+1]; 0: require mem[i] <= mem[i+1]
SIGNED, 0, 1: compare as two's complement; 0: unsigned
ERR_W, 9, error counter width
MAX_CYCLES, 25840, cycle budget from reset release to start
CYC_W, 32, cycle counter width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  single-cycle pulse requesting a scan
mem_addr  out  ADDR_W  dmem word address
mem_rdata  in  DATA_W  dmem read data, combinational (same-cycle) read
exp_addr  out  ADDR_W  expected-table word index (0..N-1)
exp_rdata  in  DATA_W  expected word, combinational read
busy  out  1  high while scanning
done  out  1  high from scan end until next start/reset
err_unsorted  out  ERR_W  order-violation count
err_exp  out  ERR_W  expected-mismatch count
pass_sorted  out  1  done && err_unsorted==0
pass_exp  out  1  done && err_exp==0
cycle_count  out  CYC_W  cycles since reset release, frozen at start
over_budget  out  1  cycle_count > MAX_CYCLES (sticky)

Behaviour:
- Reset values: busy=0, done=0, errors=0, cycle_count=0, over_budget=0, mem_addr=BASE_WORD, exp_addr=0. State is IDLE.
- FSM states IDLE -> SCAN -> DONE.
  - IDLE->SCAN on start.
  - SCAN->DONE after N reads.
  - DONE->SCAN on start (rescan).
  - reset -> IDLE from any state, including mid-scan; all counts are cleared.
- Reset and start in the same cycle: reset wins.
- start while in SCAN is ignored.
- cycle_count:
  - Increments every cycle in IDLE; saturates at all-ones.
  - Freezes on the start cycle.
  - Not cleared by a rescan from DONE.
  - over_budget sets when cycle_count exceeds MAX_CYCLES. It is informational only, does not abort the scan, and is cleared only by reset.
- SCAN uses index k = 0..N-1, one per cycle.
  - mem_addr = BASE_WORD+k and exp_addr = k, both driven from registered k.
  - Each cycle: if mem_rdata != exp_rdata, err_exp increments.
  - For k>=1: violation when DESCENDING ? cur>prev : cur<prev, using signed or unsigned compare per SIGNED. A violation increments err_unsorted.
  - cur is then registered as prev.
  - Exactly N-1 adjacent pairs are compared; no read beyond BASE_WORD+N-1.
- Error counters saturate at 2^ERR_W-1 and never wrap.
- Latency: start sampled at edge t. Reads occur during cycles t+1..t+N. done and busy-low are visible after edge t+N+1.
- Rescan from DONE: the start edge clears errors and done, then scans as above.
- Address arithmetic is modulo 2^ADDR_W. BASE_WORD+N exceeding the address space is a parameter error, flagged by an elaboration-time check.

Decomposition:
- Package sort_check_pkg holds:
  - state enum {IDLE, SCAN, DONE}
  - saturating-increment function
  - order-violation compare function (args: DESCENDING, SIGNED)
- One sub-module, cycle_budget_counter: saturating counter with freeze input and over-budget compare against MAX_CYCLES.

Test Plan:
- dmem[32..127] preloaded with 96 strictly descending unsigned values equal to the expected table; start pulse -> done after N+1 cycles, err_unsorted=0, err_exp=0, pass_sorted=1, pass_exp=1.
- Same data with dmem[40] and dmem[41] swapped -> err_unsorted=1, err_exp=2, pass_sorted=0.
- SIGNED=1, DESCENDING=0, data {32'hFFFF8A4F, 32'h0000203E, ...} ascending signed -> err_unsorted=0; same data with SIGNED=0 -> err_unsorted=1.
- ERR_W=4, expected table all zeros vs nonzero data -> err_exp saturates at 15 and does not wrap.
- Reset asserted at scan index 50 -> next cycle busy=0, errors=0, IDLE; a new start produces a full scan of N words.
- start asserted at cycle 25841 after reset release -> cycle_count=25841, over_budget=1, scan still completes; a second start during SCAN has no effect on done timing.
